// File: rtl/tick_hhmm_counter.sv
// rtl/tick_hhmm_counter.sv - BCD HH:MM time-of-day counter with button set modes, auto-repeat and blink
// Build option: define HOUR12_EN for a 01..12 hour field with a PM flag; otherwise 00..23 and pm=0.
module tick_hhmm_counter #(
  parameter logic [7:0] HH_INIT    = 8'h00,
  parameter logic [7:0] MM_INIT    = 8'h00,
  parameter int         AUTOREP_MS = 250,
  parameter int         BLINK_MS   = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce1min,
  input  logic       ce1ms,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic       set_hh,
  output logic       set_mm,
  output logic       blink,
  output logic       co_day,
  output logic       pm
);

  // Counters only need to reach (N-1); reaching it on a ce1ms pulse is the event.
  localparam int REP_W = (AUTOREP_MS > 1) ? $clog2(AUTOREP_MS) : 1;
  localparam int BLK_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(AUTOREP_MS - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_MS - 1);

  // True when v is two valid BCD digits and not above max_v.
  function automatic logic bcd_legal(input logic [7:0] v, input logic [7:0] max_v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
  endfunction

  // BCD increment wrapping max_v -> wrap_v; an illegal value also recovers to wrap_v.
  function automatic logic [7:0] bcd_step(input logic [7:0] v,
                                          input logic [7:0] max_v,
                                          input logic [7:0] wrap_v);
    logic [7:0] r;
    if (!bcd_legal(v, max_v) || (v == max_v)) begin
      r = wrap_v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'h0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

`ifdef HOUR12_EN
  localparam logic [7:0] HH_MAX  = 8'h12;
  localparam logic [7:0] HH_WRAP = 8'h01;
  localparam logic [7:0] HH_RST  = 8'h12;
`else
  localparam logic [7:0] HH_MAX  = 8'h23;
  localparam logic [7:0] HH_WRAP = 8'h00;
  localparam logic [7:0] HH_RST  = bcd_legal(HH_INIT, 8'h23) ? HH_INIT : 8'h00;
`endif
  localparam logic [7:0] MM_RST = bcd_legal(MM_INIT, 8'h59) ? MM_INIT : 8'h00;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } state_t;

  state_t state;
  state_t state_d;

  logic             mode_q;
  logic             inc_q;
  logic             armed_q;
  logic             mode_edge;
  logic             inc_edge;
  logic             in_set;
  logic [REP_W-1:0] rep_cnt;
  logic [BLK_W-1:0] blk_cnt;
  logic             rep_step;
  logic             inc_step;
  logic             minute_tick;
  logic             mm_rollover;
  logic             hh_step;
  logic             mm_step;
  logic             hour_advance;
  logic             last_hour;
  logic [7:0]       hh_next;
  logic [7:0]       mm_next;

  // Previous button levels; the first clock after reset only samples, so a held button is not an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b0;
      inc_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      mode_q  <= btn_mode;
      inc_q   <= btn_inc;
      armed_q <= 1'b1;
    end
  end

  assign mode_edge = armed_q & btn_mode & ~mode_q;
  assign inc_edge  = armed_q & btn_inc & ~inc_q;
  assign in_set    = (state != RUN);

  // Mode button cycles RUN -> SET_HH -> SET_MM -> RUN.
  always_comb begin
    state_d = state;
    if (mode_edge) begin
      case (state)
        RUN:     state_d = SET_HH;
        SET_HH:  state_d = SET_MM;
        default: state_d = RUN;
      endcase
    end
  end

  // State register with the set-mode flags decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      set_hh <= 1'b0;
      set_mm <= 1'b0;
    end else begin
      state  <= state_d;
      set_hh <= (state_d == SET_HH);
      set_mm <= (state_d == SET_MM);
    end
  end

  // A repeat fires on the ce1ms pulse that completes AUTOREP_MS held pulses.
  assign rep_step = in_set & ~mode_edge & btn_inc & ce1ms & (rep_cnt == REP_LAST);

  // Auto-repeat counter: runs only while inc is held in a set mode and the mode is not changing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (mode_edge || !in_set || !btn_inc) begin
      rep_cnt <= '0;
    end else if (ce1ms) begin
      rep_cnt <= rep_step ? '0 : rep_cnt + REP_W'(1);
    end
  end

  // Blink phase: toggles every BLINK_MS ce1ms pulses in set modes, restarts dark on every mode change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
      blink   <= 1'b0;
    end else if (mode_edge || !in_set) begin
      blk_cnt <= '0;
      blink   <= 1'b0;
    end else if (ce1ms) begin
      if (blk_cnt == BLK_LAST) begin
        blk_cnt <= '0;
        blink   <= ~blink;
      end else begin
        blk_cnt <= blk_cnt + BLK_W'(1);
      end
    end
  end

  // An edge and a repeat in the same cycle merge into one step; a mode edge swallows the step.
  assign inc_step     = in_set & ~mode_edge & (inc_edge | rep_step);
  assign hh_step      = inc_step & (state == SET_HH);
  assign mm_step      = inc_step & (state == SET_MM);
  assign minute_tick  = ce1min & (state == RUN);
  assign mm_rollover  = (mm_bcd == 8'h59);
  assign hour_advance = (minute_tick & mm_rollover) | hh_step;
  assign hh_next      = bcd_step(hh_bcd, HH_MAX, HH_WRAP);
  assign mm_next      = bcd_step(mm_bcd, 8'h59, 8'h00);

`ifdef HOUR12_EN
  assign last_hour = (hh_bcd == 8'h11) & pm;

  // PM flips when the hour passes 11 -> 12, whether by the clock or the set button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm <= 1'b0;
    end else if (hour_advance && (hh_bcd == 8'h11)) begin
      pm <= ~pm;
    end
  end
`else
  assign last_hour = (hh_bcd == 8'h23);
  assign pm        = 1'b0;
`endif

  // Time registers: minute ticks carry into hours in RUN; set-mode steps wrap within their field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hh_bcd <= HH_RST;
      mm_bcd <= MM_RST;
      co_day <= 1'b0;
    end else begin
      co_day <= 1'b0;
      if (minute_tick) begin
        mm_bcd <= mm_next;
        if (mm_rollover) begin
          hh_bcd <= hh_next;
          co_day <= last_hour;
        end
      end else if (hh_step) begin
        hh_bcd <= hh_next;
      end else if (mm_step) begin
        mm_bcd <= mm_next;
      end
    end
  end

endmodule

// File: tb/tb_tick_hhmm_counter.sv
// tb/tb_tick_hhmm_counter.sv - directed self-checking bench for tick_hhmm_counter
module tb_tick_hhmm_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce1min;
  logic       ce1ms;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] hh_bcd;
  logic [7:0] mm_bcd;
  logic       set_hh;
  logic       set_mm;
  logic       blink;
  logic       co_day;
  logic       pm;

  int checks = 0;
  int errors = 0;
  int ms_n   = 0;

  typedef struct {
    string      name;
    logic       mode;
    logic       inc;
    logic       cemin;
    logic       cems;
    logic [7:0] hh;
    logic [7:0] mm;
    logic       sh;
    logic       sm;
    logic       co;
  } vec_t;

  vec_t tab[$];

  always #5 clk = ~clk;

  tick_hhmm_counter #(
    .HH_INIT   (8'h23),
    .MM_INIT   (8'h58),
    .AUTOREP_MS(250),
    .BLINK_MS  (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ce1min  (ce1min),
    .ce1ms   (ce1ms),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .hh_bcd  (hh_bcd),
    .mm_bcd  (mm_bcd),
    .set_hh  (set_hh),
    .set_mm  (set_mm),
    .blink   (blink),
    .co_day  (co_day),
    .pm      (pm)
  );

  function automatic logic [7:0] to_bcd(input int x);
    return 8'(((x / 10) * 16) + (x % 10));
  endfunction

  function automatic vec_t mkv(input string name, input logic mode, input logic inc,
                               input logic cemin, input logic cems, input logic [7:0] hh,
                               input logic [7:0] mm, input logic sh, input logic sm,
                               input logic co);
    vec_t v;
    v.name = name; v.mode = mode; v.inc = inc; v.cemin = cemin; v.cems = cems;
    v.hh = hh; v.mm = mm; v.sh = sh; v.sm = sm; v.co = co;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic mode, input logic inc, input logic cemin, input logic cems);
    btn_mode = mode;
    btn_inc  = inc;
    ce1min   = cemin;
    ce1ms    = cems;
    @(posedge clk);
    #1;
  endtask

  task automatic run_tab();
    for (int i = 0; i < tab.size(); i++) begin
      cycle(tab[i].mode, tab[i].inc, tab[i].cemin, tab[i].cems);
      chk(tab[i].name, 32'({hh_bcd, mm_bcd, set_hh, set_mm, co_day}),
          32'({tab[i].hh, tab[i].mm, tab[i].sh, tab[i].sm, tab[i].co}));
    end
    tab.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ce1min = 1'b0; ce1ms = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef HOUR12_EN
    chk("reset12", 32'({hh_bcd, mm_bcd, set_hh, set_mm, blink, co_day, pm}),
        32'({8'h12, 8'h58, 5'b00000}));
    rst = 1'b0;
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      cycle(0, 1, 0, 0);
      chk("h12_set_am", 32'({hh_bcd, pm}), 32'({to_bcd(k), 1'b0}));
      cycle(0, 0, 0, 0);
    end
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    chk("h12_1159am", 32'({hh_bcd, mm_bcd, pm, co_day}), 32'({8'h11, 8'h59, 2'b00}));
    cycle(0, 0, 1, 0);
    chk("h12_noon", 32'({hh_bcd, mm_bcd, pm, co_day}), 32'({8'h12, 8'h00, 2'b10}));
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    for (int k = 1; k <= 11; k++) begin
      cycle(0, 1, 0, 0);
      chk("h12_set_pm", 32'({hh_bcd, pm}), 32'({to_bcd(k), 1'b1}));
      cycle(0, 0, 0, 0);
    end
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    for (int k = 1; k <= 59; k++) begin
      cycle(0, 1, 0, 0);
      cycle(0, 0, 0, 0);
    end
    chk("h12_mm59", 32'(mm_bcd), 32'(8'h59));
    cycle(1, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    chk("h12_midnight", 32'({hh_bcd, mm_bcd, pm, co_day}), 32'({8'h12, 8'h00, 2'b01}));
    cycle(0, 0, 0, 0);
    chk("h12_co_end", 32'({pm, co_day}), 32'(2'b00));
`else
    chk("reset", 32'({hh_bcd, mm_bcd, set_hh, set_mm, blink, co_day, pm}),
        32'({8'h23, 8'h58, 5'b00000}));
    rst = 1'b0;

    tab.push_back(mkv("idle_arm",     0, 0, 0, 0, 8'h23, 8'h58, 0, 0, 0));
    tab.push_back(mkv("tick_2359",    0, 0, 1, 0, 8'h23, 8'h59, 0, 0, 0));
    tab.push_back(mkv("day_wrap",     0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1));
    tab.push_back(mkv("co_pulse_end", 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
    tab.push_back(mkv("tick_0001",    0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 0));
    run_tab();

    for (int k = 0; k < 100; k++) begin
      cycle(0, 0, 0, 0);
      chk("idle_hold", 32'({hh_bcd, mm_bcd, co_day}), 32'({8'h00, 8'h01, 1'b0}));
    end

    for (int k = 2; k <= 60; k++) begin
      cycle(0, 0, 1, 0);
      chk("run_count", 32'({hh_bcd, mm_bcd, co_day}), 32'({to_bcd(k / 60), to_bcd(k % 60), 1'b0}));
    end

    tab.push_back(mkv("mode_and_tick",  1, 0, 1, 0, 8'h01, 8'h01, 1, 0, 0));
    tab.push_back(mkv("sethh_tick_ign", 0, 0, 1, 0, 8'h01, 8'h01, 1, 0, 0));
    tab.push_back(mkv("sethh_inc",      0, 1, 0, 0, 8'h02, 8'h01, 1, 0, 0));
    tab.push_back(mkv("sethh_rel",      0, 0, 0, 0, 8'h02, 8'h01, 1, 0, 0));
    tab.push_back(mkv("sethh_inc_tick", 0, 1, 1, 0, 8'h03, 8'h01, 1, 0, 0));
    tab.push_back(mkv("sethh_rel2",     0, 0, 0, 0, 8'h03, 8'h01, 1, 0, 0));
    run_tab();

    for (int k = 1; k <= 24; k++) begin
      cycle(0, 1, 0, 0);
      chk("sethh_wrap", 32'({hh_bcd, mm_bcd, co_day}), 32'({to_bcd((3 + k) % 24), 8'h01, 1'b0}));
      cycle(0, 0, 0, 0);
    end

    tab.push_back(mkv("mode_inc_same",  1, 1, 0, 0, 8'h03, 8'h01, 0, 1, 0));
    tab.push_back(mkv("setmm_release",  0, 0, 0, 0, 8'h03, 8'h01, 0, 1, 0));
    tab.push_back(mkv("setmm_inc",      0, 1, 0, 0, 8'h03, 8'h02, 0, 1, 0));
    tab.push_back(mkv("setmm_tick_ign", 0, 0, 1, 0, 8'h03, 8'h02, 0, 1, 0));
    run_tab();

    for (int k = 1; k <= 60; k++) begin
      cycle(0, 1, 0, 0);
      chk("setmm_wrap", 32'({hh_bcd, mm_bcd, co_day}), 32'({8'h03, to_bcd((2 + k) % 60), 1'b0}));
      cycle(0, 0, 0, 0);
    end
    chk("blink_idle", 32'(blink), 32'(1'b0));

    for (int k = 1; k <= 1100; k++) begin
      cycle(0, 1, 0, 1);
      ms_n++;
      chk("autorep", 32'({mm_bcd, blink}), 32'({to_bcd(3 + k / 250), 1'((ms_n / 8) % 2)}));
    end
    for (int k = 1; k <= 300; k++) begin
      cycle(0, 0, 0, 1);
      ms_n++;
      chk("rep_release", 32'({mm_bcd, blink}), 32'({8'h07, 1'((ms_n / 8) % 2)}));
    end
    for (int k = 1; k <= 200; k++) begin
      cycle(0, 1, 0, 1);
      ms_n++;
      chk("rep_restart", 32'({mm_bcd, blink}), 32'({8'h08, 1'((ms_n / 8) % 2)}));
    end
    cycle(0, 0, 0, 0);

    cycle(1, 0, 0, 0);
    chk("to_run", 32'({hh_bcd, mm_bcd, set_hh, set_mm, blink}), 32'({8'h03, 8'h08, 3'b000}));
    cycle(0, 0, 0, 0);
    for (int k = 0; k < 300; k++) begin
      cycle(0, 1, 0, 1);
      chk("run_inc_ign", 32'({mm_bcd, blink}), 32'({8'h08, 1'b0}));
    end
    cycle(0, 0, 0, 0);

    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
    chk("preset_inc", 32'({hh_bcd, set_hh}), 32'({8'h04, 1'b1}));
    #3;
    btn_mode = 1'b1;
    rst = 1'b1;
    #1;
    chk("async_reset", 32'({hh_bcd, mm_bcd, set_hh, set_mm, blink, co_day, pm}),
        32'({8'h23, 8'h58, 5'b00000}));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle(1, 1, 0, 0);
      chk("held_no_edge", 32'({hh_bcd, mm_bcd, set_hh, set_mm}), 32'({8'h23, 8'h58, 2'b00}));
    end
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("edge_after_rst", 32'({set_hh, set_mm}), 32'(2'b10));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
